dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the datapath's MEM-stage data port.
- Accepts the datapath's enable, write-enable, byte-select, address and aligned write-data outputs.
- Serves each request from an internal word-wide array after a programmable wait.
- Drives the raw read word and the stall request that the hazard unit consumes as stallreq_from_mem. Load sign/zero extraction stays in MEM.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH words.
- LATENCY, 2, number of WAIT cycles per access; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- mem_en  input  1  request valid (data port enable).
- mem_we  input  1  1 = store, 0 = load.
- sel  input  4  byte enables; sel[i] covers wdata[8i+7:8i].
- mem_addr  input  32  byte address; word index is mem_addr[ADDR_WIDTH+1:2].
- mem_wdata  input  32  store data, already lane-aligned.
- hold  input  1  MEM stage held for a reason other than this block (if/ex/wb stall). Must not depend combinationally on stallreq.
- flush  input  1  MEM-stage flush (exception or eret).
- mem_rdata  output  32  raw read word.
- stallreq  output  1  to the hazard unit as stallreq_from_mem.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, counter=0, mem_rdata=0, stallreq=0, busy=0.
  - No array write occurs in that cycle.
  - Array contents are not reset.
  - Reset in WAIT aborts the access; a pending store is discarded.
- States: IDLE, WAIT, DONE.
- stallreq = (IDLE & mem_en & ~flush) | WAIT. This is combinational from state and inputs, so the requesting cycle stalls immediately.
- IDLE:
  - If mem_en & ~flush: latch addr/we/sel/wdata, counter <= LATENCY-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If flush: go to IDLE. No write; mem_rdata is unchanged.
  - Else if counter != 0: counter decrements.
  - Else (counter == 0):
    - Load: mem_rdata <= array[latched index].
    - Store: array bytes with latched sel[i]=1 are updated; mem_rdata is unchanged.
    - In both cases, go to DONE.
- Stall length: stallreq is high for LATENCY+1 consecutive cycles per access (the issue cycle plus LATENCY WAIT cycles).
- DONE:
  - stallreq=0 and mem_rdata is valid.
  - If flush or ~hold: go to IDLE; the pipeline consumes the result this cycle.
  - If hold: stay in DONE and keep mem_rdata stable. The still-presented request is not re-issued and a store is not repeated.
- A request seen in IDLE the cycle after DONE is a new instruction and starts a new access.
- Input changes during WAIT or DONE are ignored; only latched values are used.
- sel=4'b0000 with mem_we=1: full latency, no byte changes.
- Address handling: mem_addr[1:0] is ignored (alignment errors are raised upstream). Bits above ADDR_WIDTH+1 are ignored, so addresses alias.
- flush and hold both high in DONE: flush wins and the state goes to IDLE.
- Array read/write is a single-port synchronous access in the counter==0 WAIT cycle only.

Test Plan:
1. Reset, LATENCY=2; store mem_addr=0x10, sel=4'hF, wdata=0xDEADBEEF held until stallreq falls -> stallreq high exactly 3 cycles, then DONE. A following load from 0x10 returns mem_rdata=0xDEADBEEF, again after 3 stall cycles.
2. Byte store: sel=4'b0010, wdata=0x0000AB00 to 0x10, then load 0x10 -> 0xDEADABEF. Then sel=0 store of 0xFFFFFFFF, then load -> still 0xDEADABEF.
3. Load 0x10 completes while hold=1 for 4 cycles -> stays DONE, mem_rdata=0xDEADABEF stable, stallreq=0, no second access (busy stays 1). After hold falls -> IDLE next cycle.
4. Store 0x55AA55AA to 0x20 with flush pulsed in the 2nd WAIT cycle -> state returns to IDLE, stallreq drops, and a later load of 0x20 returns the prior contents. Also, flush together with mem_en in IDLE -> stallreq=0, no access.
5. rst asserted mid-WAIT of a store of 0x12345678 to 0x30 -> next cycle mem_rdata=0, stallreq=0, busy=0, and 0x30 is unchanged.
6. Aliasing (ADDR_WIDTH=10): store 0xCAFEF00D to 0x1004, load 0x0004 -> 0xCAFEF00D. Repeat with LATENCY=1 (2 stall cycles) and LATENCY=15 (16 stall cycles).

Source files
------------

// File: rtl/dmem_responder_if.sv
// MEM-stage data-port bundle between the datapath (master) and the memory responder (slave).
// A request is presented with mem_en=1. The responder raises stallreq in the issue cycle and
// through its whole wait. The first cycle the request is present with stallreq=0 is the cycle
// in which mem_rdata is valid and the pipeline consumes the result.
interface dmem_responder_if;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        hold;
  logic        flush;
  logic [31:0] mem_rdata;
  logic        stallreq;
  logic        busy;

  modport master (
    output mem_en, mem_we, sel, mem_addr, mem_wdata, hold, flush,
    input  mem_rdata, stallreq, busy
  );

  modport slave (
    input  mem_en, mem_we, sel, mem_addr, mem_wdata, hold, flush,
    output mem_rdata, stallreq, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data memory with a programmable access latency.
// It answers MEM-stage loads and stores and stalls the pipeline while an access is in flight.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus,
  output logic [1:0]      dbg_state
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [3:0]            cnt;
  logic                  lat_we;
  logic [3:0]            lat_sel;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic [31:0]           lat_wdata;
  logic [31:0]           rdata_q;
  logic                  issue;
  logic                  access;
  logic                  unused_addr_bits;

  logic [31:0] mem_array [DEPTH];

  // Byte offset and high address bits play no part in word selection; high bits alias.
  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_WIDTH+2], bus.mem_addr[1:0]};

  assign issue  = (state == IDLE) && bus.mem_en && !bus.flush;
  assign access = (state == WAIT) && !bus.flush && (cnt == 4'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (issue) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.flush)          state_nxt = IDLE;
        else if (cnt == 4'd0)   state_nxt = DONE;
      end
      DONE: begin
        // flush takes priority over hold; the result is never re-issued from DONE
        if (bus.flush || !bus.hold) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rdata_q   <= 32'd0;
      lat_we    <= 1'b0;
      lat_sel   <= 4'd0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        lat_we    <= bus.mem_we;
        lat_sel   <= bus.sel;
        lat_idx   <= bus.mem_addr[ADDR_WIDTH+1:2];
        lat_wdata <= bus.mem_wdata;
        cnt       <= CNT_LOAD;
      end else if ((state == WAIT) && !bus.flush && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !lat_we) rdata_q <= mem_array[lat_idx];
    end
  end

  // Array contents survive reset; only the write is suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && access && lat_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_sel[i]) mem_array[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.stallreq  = issue || (state == WAIT);
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) checked against a word/byte
// memory model that also tracks the last value mem_rdata should hold.
module tb_dmem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [2:0]       en, we, hold, flush;
  logic [2:0][3:0]  sel;
  logic [2:0][31:0] addr, wdata;
  logic [2:0][31:0] rdata;
  logic [2:0]       stall, busy;
  logic [1:0]       dbg0, dbg1, dbg2;

  dmem_responder_if bus0 ();
  dmem_responder_if bus1 ();
  dmem_responder_if bus2 ();

  assign bus0.mem_en = en[0];  assign bus0.mem_we = we[0];  assign bus0.sel = sel[0];
  assign bus0.mem_addr = addr[0];  assign bus0.mem_wdata = wdata[0];
  assign bus0.hold = hold[0];  assign bus0.flush = flush[0];
  assign bus1.mem_en = en[1];  assign bus1.mem_we = we[1];  assign bus1.sel = sel[1];
  assign bus1.mem_addr = addr[1];  assign bus1.mem_wdata = wdata[1];
  assign bus1.hold = hold[1];  assign bus1.flush = flush[1];
  assign bus2.mem_en = en[2];  assign bus2.mem_we = we[2];  assign bus2.sel = sel[2];
  assign bus2.mem_addr = addr[2];  assign bus2.mem_wdata = wdata[2];
  assign bus2.hold = hold[2];  assign bus2.flush = flush[2];

  assign rdata = {bus2.mem_rdata, bus1.mem_rdata, bus0.mem_rdata};
  assign stall = {bus2.stallreq, bus1.stallreq, bus0.stallreq};
  assign busy  = {bus2.busy, bus1.busy, bus0.busy};

  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(2))  u_lat2  (.clk(clk), .rst(rst), .bus(bus0), .dbg_state(dbg0));
  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(1))  u_lat1  (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));
  dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(15)) u_lat15 (.clk(clk), .rst(rst), .bus(bus2), .dbg_state(dbg2));

  int checks = 0;
  int fails  = 0;

  // Reference: memory words by word index, and the value mem_rdata must show.
  logic [31:0] model [3][1024];
  logic [31:0] exp_rdata [3];

  function automatic int lat_of(int k);
    case (k)
      0: return 2;
      1: return 1;
      default: return 15;
    endcase
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 1024);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access on instance k, with hold kept high for hold_n DONE cycles.
  task automatic access(int k, bit w, logic [31:0] a, logic [3:0] s, logic [31:0] d,
                        int hold_n, string tag);
    int n;
    @(negedge clk);
    en[k] = 1'b1; we[k] = w; addr[k] = a; sel[k] = s; wdata[k] = d;
    hold[k] = (hold_n > 0); flush[k] = 1'b0;
    n = 0;
    #1;
    while (stall[k] === 1'b1 && n < 40) begin
      n++;
      @(negedge clk); #1;
    end
    check({tag, " stall_len"}, 32'(n), 32'(lat_of(k) + 1));
    check({tag, " busy_done"}, 32'(busy[k]), 32'd1);
    if (w) model[k][widx(a)] = merge(model[k][widx(a)], d, s);
    else   exp_rdata[k] = model[k][widx(a)];
    check({tag, " rdata"}, rdata[k], exp_rdata[k]);
    // Inputs changing while DONE must not matter.
    addr[k] = $urandom; wdata[k] = $urandom; sel[k] = 4'($urandom_range(0, 15)); we[k] = ~w;
    for (int i = 1; i < hold_n; i++) begin
      @(negedge clk); #1;
      check({tag, " hold_stall"}, 32'(stall[k]), 32'd0);
      check({tag, " hold_busy"}, 32'(busy[k]), 32'd1);
      check({tag, " hold_rdata"}, rdata[k], exp_rdata[k]);
    end
    hold[k] = 1'b0; en[k] = 1'b0;
    @(negedge clk); #1;
    check({tag, " idle_busy"}, 32'(busy[k]), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en = '0; we = '0; hold = '0; flush = '0; sel = '0; addr = '0; wdata = '0;
    for (int k = 0; k < 3; k++) exp_rdata[k] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    for (int k = 0; k < 3; k++) begin
      check("reset_rdata", rdata[k], 32'd0);
      check("reset_stall", 32'(stall[k]), 32'd0);
      check("reset_busy", 32'(busy[k]), 32'd0);
    end

    // Full-word store then load.
    access(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, "t1_st");
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0, "t1_ld");
    // Single-lane store and sel=0 store.
    access(0, 1'b1, 32'h10, 4'b0010, 32'h0000AB00, 0, "t2_st_b1");
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0, "t2_ld_b1");
    check("t2_value", rdata[0], 32'hDEADABEF);
    access(0, 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0, "t2_st_sel0");
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, 0, "t2_ld_sel0");
    check("t2_sel0_value", rdata[0], 32'hDEADABEF);
    // Load completing under a 4-cycle hold.
    access(0, 1'b0, 32'h10, 4'hF, 32'h0, 4, "t3_hold");

    // Store flushed in its final WAIT cycle.
    access(0, 1'b1, 32'h20, 4'hF, 32'h11112222, 0, "t4_pre");
    @(negedge clk);
    en[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; sel[0] = 4'hF; wdata[0] = 32'h55AA55AA; #1;
    check("t4_issue_stall", 32'(stall[0]), 32'd1);
    @(negedge clk); en[0] = 1'b0; #1;
    check("t4_wait1_stall", 32'(stall[0]), 32'd1);
    @(negedge clk); flush[0] = 1'b1; #1;
    check("t4_wait2_stall", 32'(stall[0]), 32'd1);
    @(negedge clk); flush[0] = 1'b0; #1;
    check("t4_flush_stall", 32'(stall[0]), 32'd0);
    check("t4_flush_busy", 32'(busy[0]), 32'd0);
    check("t4_flush_rdata", rdata[0], exp_rdata[0]);
    // Request together with flush in IDLE is dropped.
    @(negedge clk);
    en[0] = 1'b1; flush[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h20; #1;
    check("t4_idle_flush_stall", 32'(stall[0]), 32'd0);
    @(negedge clk); en[0] = 1'b0; flush[0] = 1'b0; #1;
    check("t4_idle_flush_busy", 32'(busy[0]), 32'd0);
    access(0, 1'b0, 32'h20, 4'hF, 32'h0, 0, "t4_ld");

    // Reset in the WAIT cycle that would have written.
    access(0, 1'b1, 32'h30, 4'hF, 32'hA5A5_0F0F, 0, "t5_pre");
    @(negedge clk);
    en[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h30; sel[0] = 4'hF; wdata[0] = 32'h12345678;
    @(negedge clk); en[0] = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    for (int k = 0; k < 3; k++) exp_rdata[k] = 32'd0;
    check("t5_rst_rdata", rdata[0], 32'd0);
    check("t5_rst_stall", 32'(stall[0]), 32'd0);
    check("t5_rst_busy", 32'(busy[0]), 32'd0);
    access(0, 1'b0, 32'h30, 4'hF, 32'h0, 0, "t5_ld");

    // Address aliasing on every latency.
    for (int k = 0; k < 3; k++) begin
      access(k, 1'b1, 32'h1004, 4'hF, 32'hCAFEF00D, 0, "t6_st");
      access(k, 1'b0, 32'h0004, 4'hF, 32'h0, 0, "t6_ld");
      check("t6_value", rdata[k], 32'hCAFEF00D);
    end

    // Random traffic over a small set of words, with aliased high bits and byte offsets.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++)
        access(k, 1'b1, 32'((100 + 7 * j) * 4), 4'hF, $urandom, 0, "rnd_init");
      for (int j = 0; j < 12; j++) begin
        logic [31:0] a;
        a = {20'($urandom), 10'(100 + 7 * $urandom_range(0, 3)), 2'($urandom_range(0, 3))};
        access(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
               $urandom_range(0, 3), "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
